handshake_stream_packer: RTL and testbench
==========================================

Name: handshake_stream_packer

Overview:
- Collects N consecutive W-bit beats from a valid/ready stream and emits one N*W-bit beat on a valid/ready stream.
- Short groups are closed early by `input_last`.
- Sits directly upstream of the pipelined handshake slice register that carries wide payloads across long routes in the compressor datapath.
- Its output drives that slice's input, so its `output_ready` is the slice's registered ready (one cycle stale) and must be honoured exactly.

Parameters:
- W, default 8: width of one input lane in bits.
- N, default 4: lanes per output beat. N >= 1.
- CW, default $clog2(N+1): width of `output_count`.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset.
- input_valid  input  1  upstream beat valid.
- input_ready  output  1  packer can accept a beat this cycle.
- input_payload  input  W  upstream lane data.
- input_last  input  1  this beat closes the current group.
- output_valid  output  1  packed beat valid.
- output_ready  input  1  downstream accepts the packed beat.
- output_payload  output  N*W  packed data; lane k at bits [k*W +: W], lane 0 is the first accepted beat.
- output_keep  output  N  bit k set when lane k holds data.
- output_count  output  CW  number of valid lanes, 1..N.
- output_last  output  1  group was closed by `input_last`.

Interface constraint (already decided): one clock; reset is synchronous and active-high.

Behaviour:
- Handshake:
  - Input fire = input_valid && input_ready.
  - Output fire = output_valid && output_ready.
  - `input_ready` is combinational: input_ready = !output_valid || output_ready. It never depends on `input_valid`.
  - No combinational path from `input_*` to `output_*`.
- State:
  - Lane buffer (N*W bits), keep mask (N bits), lane counter cnt (0..N-1), out_valid flag, out_last flag.
  - Buffer, keep and count drive `output_payload`, `output_keep` and `output_count` directly.
  - `output_count` is the popcount of keep; it may be kept as a register.
- Reset (rst=1 at a clock edge):
  - output_valid=0, output_last=0, output_keep=0, output_count=0, output_payload=0, cnt=0.
  - While rst=1, input_ready=1; any input fire during reset is discarded.
  - Reset mid-group drops partial lanes; nothing is emitted for them.
- Accumulating (output_valid=0), on input fire:
  - Write the payload into lane cnt and set keep[cnt].
  - If cnt==N-1 or input_last: set output_valid=1, set output_last=input_last, cnt<=0.
  - Otherwise cnt<=cnt+1.
- Holding (output_valid=1):
  - The buffer holds. `output_payload`, `output_keep`, `output_count` and `output_last` stay stable until output fire.
  - input_ready follows output_ready.
- Output fire with no input fire:
  - output_valid<=0, keep<=0, cnt<=0.
  - Buffer lanes cleared to zero, so unused lanes always read 0.
- Output fire and input fire in the same cycle:
  - Buffer restarts with the new beat in lane 0, keep=1, all other lanes zeroed.
  - If N==1 or input_last: output_valid stays 1 and output_last=input_last.
  - Otherwise output_valid<=0 and cnt<=1.
  - No bubble is inserted.
- Latency and throughput:
  - output_valid rises in the cycle after the closing input fire.
  - Sustained rate is one output per N input beats, with no stalls when output_ready is held at 1.
- Boundary cases:
  - input_last on lane N-1: a full beat with output_last=1, no extra empty beat.
  - input_last on lane 0: keep=0001 (N=4), count=1.
  - An empty group is never emitted.
  - input_valid held with input_ready=0: `input_payload` must be held stable by upstream; the packer samples only on fire.

Test Plan (W=8, N=4):
1. Reset: hold rst=1 for 3 cycles with input_valid=1 -> output_valid=0, output_keep=0, output_payload=0 throughout; after rst falls, the first beat lands in lane 0.
2. Full group: send 11,22,33,44 on consecutive cycles with output_ready=1 -> one cycle after 44 is accepted, output_payload=0x44332211, keep=1111, count=4, last=0, valid for exactly 1 cycle.
3. Short group: send AA, then BB with input_last=1 -> output_payload=0x0000BBAA, keep=0011, count=2, last=1; the next group starts in lane 0.
4. Backpressure: complete a group, hold output_ready=0 for 5 cycles while input_valid=1 -> input_ready=0 for all 5 cycles and the output is stable; release -> same cycle the output fires and the pending input is accepted into lane 0.
5. Streaming: send 12 beats with input_valid=1 and output_ready=1 -> 3 packed beats on cycles 5, 9 and 13 (counting the first input fire as cycle 1), no input_ready deassertion, data in order.
6. Mid-group reset: accept 3 beats, then pulse rst for 1 cycle -> no output beat; next group 01,02,03,04 gives 0x04030201, keep=1111.

Source files
------------

// File: rtl/handshake_stream_packer_if.sv
// Boundary bundle of the stream packer: narrow input stream in, wide packed stream out.
// Pure wiring: no storage, no latency.
// Backpressure travels on input_ready / output_ready; master is the packer, slave is its environment.
interface handshake_stream_packer_if #(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int CW = $clog2(N + 1)
);
    logic             input_valid;
    logic             input_ready;
    logic [W-1:0]     input_payload;
    logic             input_last;
    logic             output_valid;
    logic             output_ready;
    logic [N*W-1:0]   output_payload;
    logic [N-1:0]     output_keep;
    logic [CW-1:0]    output_count;
    logic             output_last;

    modport master (
        input  input_valid, input_payload, input_last, output_ready,
        output input_ready, output_valid, output_payload, output_keep,
        output output_count, output_last
    );

    modport slave (
        output input_valid, input_payload, input_last, output_ready,
        input  input_ready, output_valid, output_payload, output_keep,
        input  output_count, output_last
    );
endinterface

// File: rtl/handshake_stream_packer.sv
// Packs up to N consecutive W-bit beats into one N*W-bit beat; input_last closes a group early.
// Latency: packed beat valid the cycle after the closing input fire; full throughput, no bubbles.
// Backpressure: input_ready = !output_valid || output_ready, combinational from the registered output state only.
module handshake_stream_packer #(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int CW = $clog2(N + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    handshake_stream_packer_if.master  bus
);
    // Lane index width; a single-lane packer still needs one bit to keep the logic legal.
    localparam int CNTW = (N > 1) ? $clog2(N) : 1;

    logic [N*W-1:0]  r_buf;
    logic [N-1:0]    r_keep;
    logic [CW-1:0]   r_count;
    logic [CNTW-1:0] r_cnt;
    logic            r_valid;
    logic            r_last;

    logic            w_in_rdy;
    logic            w_in_fire;
    logic            w_out_fire;
    logic [CNTW-1:0] w_base;

    logic [N*W-1:0]  w_nxt_buf;
    logic [N-1:0]    w_nxt_keep;
    logic [CW-1:0]   w_nxt_count;
    logic [CNTW-1:0] w_nxt_cnt;
    logic            w_nxt_valid;
    logic            w_nxt_last;

    // Ready while reset is held so upstream never stalls on us; fires during reset are dropped below.
    assign w_in_rdy   = rst || !r_valid || bus.output_ready;
    assign w_in_fire  = bus.input_valid && w_in_rdy;
    assign w_out_fire = r_valid && bus.output_ready;

    // A beat accepted in the same cycle the packed beat leaves starts a fresh group in lane 0.
    assign w_base = w_out_fire ? '0 : r_cnt;

    // Next-state: drain on output fire, then merge any accepted beat on top of the (possibly cleared) buffer.
    always_comb begin
        w_nxt_buf   = r_buf;
        w_nxt_keep  = r_keep;
        w_nxt_count = r_count;
        w_nxt_cnt   = r_cnt;
        w_nxt_valid = r_valid;
        w_nxt_last  = r_last;

        if (w_out_fire) begin
            w_nxt_buf   = '0;
            w_nxt_keep  = '0;
            w_nxt_count = '0;
            w_nxt_cnt   = '0;
            w_nxt_valid = 1'b0;
            w_nxt_last  = 1'b0;
        end

        if (w_in_fire) begin
            w_nxt_buf[w_base*W +: W] = bus.input_payload;
            w_nxt_keep[w_base]       = 1'b1;
            w_nxt_count              = CW'(w_base) + CW'(1);
            if ((w_base == CNTW'(N - 1)) || bus.input_last) begin
                w_nxt_valid = 1'b1;
                w_nxt_last  = bus.input_last;
                w_nxt_cnt   = '0;
            end else begin
                w_nxt_cnt   = w_base + CNTW'(1);
            end
        end
    end

    // State register; reset wipes any partial group so nothing is emitted for it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf   <= '0;
            r_keep  <= '0;
            r_count <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_buf   <= w_nxt_buf;
            r_keep  <= w_nxt_keep;
            r_count <= w_nxt_count;
            r_cnt   <= w_nxt_cnt;
            r_valid <= w_nxt_valid;
            r_last  <= w_nxt_last;
        end
    end

    assign bus.input_ready    = w_in_rdy;
    assign bus.output_valid   = r_valid;
    assign bus.output_payload = r_buf;
    assign bus.output_keep    = r_keep;
    assign bus.output_count   = r_count;
    assign bus.output_last    = r_last;
endmodule

// File: tb/tb_handshake_stream_packer.sv
// Directed bench for the stream packer at W=8, N=4.
// Inputs driven 1 time unit after the rising edge, outputs checked on the falling edge.
// Table-driven vectors first, then hand-written backpressure, streaming and mid-group reset sequences.
module tb_handshake_stream_packer;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int CW = $clog2(N + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    handshake_stream_packer_if #(.W(W), .N(N), .CW(CW)) bus ();

    handshake_stream_packer #(.W(W), .N(N), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rst;
        logic        vld;
        logic [7:0]  pl;
        logic        lst;
        logic        ordy;
        logic        e_irdy;
        logic        e_ovld;
        logic [31:0] e_pl;
        logic [3:0]  e_keep;
        logic [2:0]  e_cnt;
        logic        e_last;
    } vec_t;

    vec_t tbl [21];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    // One clock: drive just after the rising edge, return at the falling edge ready for checks.
    task automatic cyc(input logic r, input logic v, input logic [7:0] p, input logic l, input logic ordy);
        @(posedge clk);
        #1;
        rst               = r;
        bus.input_valid   = v;
        bus.input_payload = p;
        bus.input_last    = l;
        bus.output_ready  = ordy;
        @(negedge clk);
    endtask

    task automatic chk_out(input string nm, input logic irdy, input logic ovld,
                           input logic [31:0] pl, input logic [3:0] keep, input logic [2:0] cnt);
        chk({nm, ".input_ready"},  32'(bus.input_ready),  32'(irdy));
        chk({nm, ".output_valid"}, 32'(bus.output_valid), 32'(ovld));
        chk({nm, ".payload"},      bus.output_payload,    pl);
        chk({nm, ".keep"},         32'(bus.output_keep),  32'(keep));
        chk({nm, ".count"},        32'(bus.output_count), 32'(cnt));
    endtask

    initial begin
        bus.input_valid   = 1'b1;
        bus.input_payload = 8'hEE;
        bus.input_last    = 1'b0;
        bus.output_ready  = 1'b1;

        //            rst vld pl     lst ordy  irdy ovld payload        keep   cnt  last
        tbl[0]  = '{1'b1, 1'b1, 8'hEE, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'h0, 3'd0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 8'hEE, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'h0, 3'd0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 8'hEE, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'h0, 3'd0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'h0, 3'd0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000011, 4'h1, 3'd1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00002211, 4'h3, 3'd2, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00332211, 4'h7, 3'd3, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 32'h44332211, 4'hF, 3'd4, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'h0, 3'd0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'h0, 3'd0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 8'hBB, 1'b1, 1'b1, 1'b1, 1'b0, 32'h000000AA, 4'h1, 3'd1, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 8'hCC, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000BBAA, 4'h3, 3'd2, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h000000CC, 4'h1, 3'd1, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 32'h000000CC, 4'h1, 3'd1, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'h0, 3'd0, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'h0, 3'd0, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000001, 4'h1, 3'd1, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000201, 4'h3, 3'd2, 1'b0};
        tbl[18] = '{1'b0, 1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00030201, 4'h7, 3'd3, 1'b0};
        tbl[19] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 32'h04030201, 4'hF, 3'd4, 1'b1};
        tbl[20] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'h0, 3'd0, 1'b0};

        // Reset, full group, short group, last on lane 0 with a stall, last on lane N-1.
        for (int i = 0; i < 21; i++) begin
            cyc(tbl[i].rst, tbl[i].vld, tbl[i].pl, tbl[i].lst, tbl[i].ordy);
            chk_out($sformatf("vec%0d", i), tbl[i].e_irdy, tbl[i].e_ovld,
                    tbl[i].e_pl, tbl[i].e_keep, tbl[i].e_cnt);
            if (tbl[i].e_ovld)
                chk($sformatf("vec%0d.last", i), 32'(bus.output_last), 32'(tbl[i].e_last));
        end

        // Backpressure: full group, then 5 stalled cycles with a beat waiting upstream.
        cyc(1'b0, 1'b1, 8'hA1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 8'hA2, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 8'hA3, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 8'hA4, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 8'hB5, 1'b0, 1'b0);
            chk_out($sformatf("bp_stall%0d", i), 1'b0, 1'b1, 32'hA4A3A2A1, 4'hF, 3'd4);
            chk($sformatf("bp_stall%0d.last", i), 32'(bus.output_last), 32'd0);
        end
        cyc(1'b0, 1'b1, 8'hB5, 1'b0, 1'b1);
        chk_out("bp_release", 1'b1, 1'b1, 32'hA4A3A2A1, 4'hF, 3'd4);
        cyc(1'b0, 1'b1, 8'hB6, 1'b1, 1'b1);
        chk_out("bp_after", 1'b1, 1'b0, 32'h000000B5, 4'h1, 3'd1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk_out("bp_tail", 1'b1, 1'b1, 32'h0000B6B5, 4'h3, 3'd2);
        chk("bp_tail.last", 32'(bus.output_last), 32'd1);

        // Streaming: 12 beats back to back, packed beats visible on cycles 5, 9 and 13.
        for (int c = 1; c <= 14; c++) begin
            logic [7:0] b0;
            b0 = 8'h50 + 8'(c - 5);
            cyc(1'b0, c <= 12, 8'h50 + 8'(c - 1), 1'b0, 1'b1);
            chk($sformatf("stream%0d.input_ready", c), 32'(bus.input_ready), 32'd1);
            chk($sformatf("stream%0d.output_valid", c), 32'(bus.output_valid),
                32'((c == 5) || (c == 9) || (c == 13)));
            if ((c == 5) || (c == 9) || (c == 13)) begin
                chk($sformatf("stream%0d.payload", c), bus.output_payload,
                    {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0});
                chk($sformatf("stream%0d.keep", c), 32'(bus.output_keep), 32'hF);
            end
        end

        // Mid-group reset: three lanes dropped, reset asserted with downstream stalled.
        cyc(1'b0, 1'b1, 8'h61, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 8'h62, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 8'h63, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 8'h64, 1'b0, 1'b0);
        chk("mrst.input_ready", 32'(bus.input_ready), 32'd1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk_out("mrst_idle", 1'b1, 1'b0, 32'h0, 4'h0, 3'd0);
        cyc(1'b0, 1'b1, 8'h01, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 8'h02, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 8'h03, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 8'h04, 1'b0, 1'b1);
        chk_out("mrst_pre", 1'b1, 1'b0, 32'h00030201, 4'h7, 3'd3);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk_out("mrst_group", 1'b1, 1'b1, 32'h04030201, 4'hF, 3'd4);
        chk("mrst_group.last", 32'(bus.output_last), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
